// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer.
// Takes RGMII samples that are already split into rising and falling halves on
// the system clock. Strips the preamble and SFD, assembles bytes from gigabit
// or 10/100 nibble samples, and emits a byte stream with end-of-frame and
// error flags. One byte is held back so that tlast can go out with the final
// byte of the frame.
// Only DATA_WIDTH = 4 is meaningful; it sets the width of the RXD halves.
module rgmii_rx_deframer #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rgmii_rxd_rise,
    input  logic [DATA_WIDTH-1:0] rgmii_rxd_fall,
    input  logic                  rgmii_rx_ctl_rise,
    input  logic                  rgmii_rx_ctl_fall,
    input  logic                  rgmii_clk_en,
    input  logic                  rgmii_mii_sel,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  stat_start_packet,
    output logic                  stat_error_bad_frame,
    output logic                  stat_error_preamble
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_DROP     = 2'd3
    } state_t;

    // Registered state
    state_t     state_r;
    logic       dv_prev_r;
    logic [7:0] hold_r;
    logic       hold_full_r;
    logic       phase_r;
    logic [3:0] nib0_r;
    logic       frame_err_r;
    logic       mii_mode_r;
    logic       pre_seen_r;
    logic [7:0] tdata_r;
    logic       tvalid_r;
    logic       tlast_r;
    logic       tuser_r;
    logic       start_r;
    logic       bad_frame_r;
    logic       pre_err_r;

    // Next-state values
    state_t     state_nxt_s;
    logic       dv_prev_nxt_s;
    logic [7:0] hold_nxt_s;
    logic       hold_full_nxt_s;
    logic       phase_nxt_s;
    logic [3:0] nib0_nxt_s;
    logic       frame_err_nxt_s;
    logic       mii_mode_nxt_s;
    logic       pre_seen_nxt_s;
    logic [7:0] tdata_nxt_s;
    logic       tvalid_nxt_s;
    logic       tlast_nxt_s;
    logic       tuser_nxt_s;
    logic       start_nxt_s;
    logic       bad_frame_nxt_s;
    logic       pre_err_nxt_s;

    // Decoded sample
    logic       dv_s;
    logic       er_s;
    logic [7:0] gbyte_s;
    logic [3:0] nib_s;
    logic       byte_done_s;
    logic [7:0] byte_s;
    logic       end_user_s;

    // Decode one RGMII sample: DV, error and the gigabit byte / MII nibble.
    always_comb begin
        dv_s    = rgmii_rx_ctl_rise;
        er_s    = rgmii_rx_ctl_rise ^ rgmii_rx_ctl_fall;
        gbyte_s = {rgmii_rxd_fall, rgmii_rxd_rise};
        nib_s   = rgmii_rxd_rise;
    end

    // Next-state and output decode; nothing advances on samples without clk_en.
    always_comb begin
        state_nxt_s     = state_r;
        dv_prev_nxt_s   = dv_prev_r;
        hold_nxt_s      = hold_r;
        hold_full_nxt_s = hold_full_r;
        phase_nxt_s     = phase_r;
        nib0_nxt_s      = nib0_r;
        frame_err_nxt_s = frame_err_r;
        mii_mode_nxt_s  = mii_mode_r;
        pre_seen_nxt_s  = pre_seen_r;
        tdata_nxt_s     = tdata_r;
        tvalid_nxt_s    = 1'b0;
        tlast_nxt_s     = 1'b0;
        tuser_nxt_s     = 1'b0;
        start_nxt_s     = 1'b0;
        bad_frame_nxt_s = 1'b0;
        pre_err_nxt_s   = 1'b0;
        byte_done_s     = 1'b0;
        byte_s          = 8'h00;
        end_user_s      = 1'b0;

        if (rgmii_clk_en) begin
            dv_prev_nxt_s = dv_s;
            case (state_r)
                ST_IDLE: begin
                    // Only a fresh DV rising edge opens a frame, so a frame
                    // already in flight at reset is skipped entirely.
                    if (dv_s && !dv_prev_r) begin
                        state_nxt_s    = ST_PREAMBLE;
                        pre_seen_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (!dv_s) begin
                        state_nxt_s   = ST_IDLE;
                        pre_err_nxt_s = 1'b1;
                    end else if (er_s) begin
                        state_nxt_s   = ST_DROP;
                        pre_err_nxt_s = 1'b1;
                    end else if (rgmii_mii_sel) begin
                        if (nib_s == 4'h5) begin
                            pre_seen_nxt_s = 1'b1;
                        end else if ((nib_s == 4'hD) && pre_seen_r) begin
                            state_nxt_s     = ST_PAYLOAD;
                            start_nxt_s     = 1'b1;
                            mii_mode_nxt_s  = 1'b1;
                            phase_nxt_s     = 1'b0;
                            frame_err_nxt_s = 1'b0;
                            hold_full_nxt_s = 1'b0;
                        end else begin
                            state_nxt_s   = ST_DROP;
                            pre_err_nxt_s = 1'b1;
                        end
                    end else begin
                        if (gbyte_s == 8'h55) begin
                            pre_seen_nxt_s = 1'b1;
                        end else if ((gbyte_s == 8'hD5) && pre_seen_r) begin
                            state_nxt_s     = ST_PAYLOAD;
                            start_nxt_s     = 1'b1;
                            mii_mode_nxt_s  = 1'b0;
                            phase_nxt_s     = 1'b0;
                            frame_err_nxt_s = 1'b0;
                            hold_full_nxt_s = 1'b0;
                        end else begin
                            state_nxt_s   = ST_DROP;
                            pre_err_nxt_s = 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (!dv_s) begin
                        // Frame end: flush the held byte with tlast; a dangling
                        // nibble marks the frame bad and is dropped.
                        end_user_s = frame_err_r | (mii_mode_r & phase_r);
                        if (hold_full_r) begin
                            tdata_nxt_s     = hold_r;
                            tvalid_nxt_s    = 1'b1;
                            tlast_nxt_s     = 1'b1;
                            tuser_nxt_s     = end_user_s;
                            bad_frame_nxt_s = end_user_s;
                        end else begin
                            bad_frame_nxt_s = 1'b1;
                        end
                        state_nxt_s     = ST_IDLE;
                        frame_err_nxt_s = 1'b0;
                        hold_full_nxt_s = 1'b0;
                        phase_nxt_s     = 1'b0;
                    end else begin
                        frame_err_nxt_s = frame_err_r | er_s;
                        if (mii_mode_r) begin
                            if (!phase_r) begin
                                nib0_nxt_s  = nib_s;
                                phase_nxt_s = 1'b1;
                            end else begin
                                byte_done_s = 1'b1;
                                byte_s      = {nib_s, nib0_r};
                                phase_nxt_s = 1'b0;
                            end
                        end else begin
                            byte_done_s = 1'b1;
                            byte_s      = gbyte_s;
                        end
                        // A new byte pushes the previously held one out.
                        if (byte_done_s) begin
                            if (hold_full_r) begin
                                tdata_nxt_s  = hold_r;
                                tvalid_nxt_s = 1'b1;
                            end else begin
                                tvalid_nxt_s = 1'b0;
                            end
                            hold_nxt_s      = byte_s;
                            hold_full_nxt_s = 1'b1;
                        end else begin
                            hold_full_nxt_s = hold_full_r;
                        end
                    end
                end
                ST_DROP: begin
                    if (!dv_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DROP;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            dv_prev_nxt_s = dv_prev_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            dv_prev_r   <= 1'b1;
            hold_r      <= 8'h00;
            hold_full_r <= 1'b0;
            phase_r     <= 1'b0;
            nib0_r      <= 4'h0;
            frame_err_r <= 1'b0;
            mii_mode_r  <= 1'b0;
            pre_seen_r  <= 1'b0;
            tdata_r     <= 8'h00;
            tvalid_r    <= 1'b0;
            tlast_r     <= 1'b0;
            tuser_r     <= 1'b0;
            start_r     <= 1'b0;
            bad_frame_r <= 1'b0;
            pre_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            dv_prev_r   <= dv_prev_nxt_s;
            hold_r      <= hold_nxt_s;
            hold_full_r <= hold_full_nxt_s;
            phase_r     <= phase_nxt_s;
            nib0_r      <= nib0_nxt_s;
            frame_err_r <= frame_err_nxt_s;
            mii_mode_r  <= mii_mode_nxt_s;
            pre_seen_r  <= pre_seen_nxt_s;
            tdata_r     <= tdata_nxt_s;
            tvalid_r    <= tvalid_nxt_s;
            tlast_r     <= tlast_nxt_s;
            tuser_r     <= tuser_nxt_s;
            start_r     <= start_nxt_s;
            bad_frame_r <= bad_frame_nxt_s;
            pre_err_r   <= pre_err_nxt_s;
        end
    end

    assign m_axis_tdata         = tdata_r;
    assign m_axis_tvalid        = tvalid_r;
    assign m_axis_tlast         = tlast_r;
    assign m_axis_tuser         = tuser_r;
    assign stat_start_packet    = start_r;
    assign stat_error_bad_frame = bad_frame_r;
    assign stat_error_preamble  = pre_err_r;

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// Self-checking bench for rgmii_rx_deframer: expected beats are queued as the
// payload is driven and compared by a monitor as the DUT emits them.
module tb_rgmii_rx_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rgmii_rxd_rise = 4'h0;
    logic [3:0] rgmii_rxd_fall = 4'h0;
    logic       rgmii_rx_ctl_rise = 1'b0;
    logic       rgmii_rx_ctl_fall = 1'b0;
    logic       rgmii_clk_en = 1'b0;
    logic       rgmii_mii_sel = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       stat_start_packet;
    logic       stat_error_bad_frame;
    logic       stat_error_preamble;

    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int bad_cnt = 0;
    int pre_cnt = 0;
    logic en_last = 1'b0;
    logic [9:0] sb[$];
    logic [9:0] exp_beat;
    logic [7:0] pl[0:63];
    logic [3:0] nb[0:15];

    rgmii_rx_deframer #(.DATA_WIDTH(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rgmii_rxd_rise       (rgmii_rxd_rise),
        .rgmii_rxd_fall       (rgmii_rxd_fall),
        .rgmii_rx_ctl_rise    (rgmii_rx_ctl_rise),
        .rgmii_rx_ctl_fall    (rgmii_rx_ctl_fall),
        .rgmii_clk_en         (rgmii_clk_en),
        .rgmii_mii_sel        (rgmii_mii_sel),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tuser         (m_axis_tuser),
        .stat_start_packet    (stat_start_packet),
        .stat_error_bad_frame (stat_error_bad_frame),
        .stat_error_preamble  (stat_error_preamble)
    );

    always #5 clk = ~clk;

    // Remember whether the last active edge was a qualified sample.
    always @(posedge clk) en_last <= rgmii_clk_en;

    // Monitor: compare beats against the scoreboard and count stat pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (!en_last) begin
                checks++;
                if (m_axis_tvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL beat_without_clk_en got tvalid=%b required 0", m_axis_tvalid);
                end
            end
            if (m_axis_tvalid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat got data=%02h last=%b user=%b required none",
                             m_axis_tdata, m_axis_tlast, m_axis_tuser);
                end else begin
                    exp_beat = sb.pop_front();
                    if ({m_axis_tdata, m_axis_tlast, m_axis_tuser} !== exp_beat) begin
                        failures++;
                        $display("FAIL beat got data=%02h last=%b user=%b required data=%02h last=%b user=%b",
                                 m_axis_tdata, m_axis_tlast, m_axis_tuser,
                                 exp_beat[9:2], exp_beat[1], exp_beat[0]);
                    end
                end
            end else begin
                checks++;
                if ({m_axis_tlast, m_axis_tuser} !== 2'b00) begin
                    failures++;
                    $display("FAIL flags_without_tvalid got last=%b user=%b required 0 0",
                             m_axis_tlast, m_axis_tuser);
                end
            end
            if (stat_start_packet === 1'b1) start_cnt++;
            if (stat_error_bad_frame === 1'b1) bad_cnt++;
            if (stat_error_preamble === 1'b1) pre_cnt++;
        end
    end

    task automatic gbe_sample(input logic [7:0] b, input logic dv, input logic er);
        rgmii_rxd_rise    = b[3:0];
        rgmii_rxd_fall    = b[7:4];
        rgmii_rx_ctl_rise = dv;
        rgmii_rx_ctl_fall = dv ^ er;
        rgmii_clk_en      = 1'b1;
        @(posedge clk);
        #1;
        rgmii_clk_en = 1'b0;
    endtask

    // One qualified MII sample followed by gap unqualified cycles of junk.
    task automatic mii_sample(input logic [3:0] n, input logic dv, input logic er, input int gap);
        rgmii_rxd_rise    = n;
        rgmii_rxd_fall    = n;
        rgmii_rx_ctl_rise = dv;
        rgmii_rx_ctl_fall = dv ^ er;
        rgmii_clk_en      = 1'b1;
        @(posedge clk);
        #1;
        for (int g = 0; g < gap; g++) begin
            rgmii_clk_en      = 1'b0;
            rgmii_rxd_rise    = 4'($urandom_range(0, 15));
            rgmii_rxd_fall    = 4'($urandom_range(0, 15));
            rgmii_rx_ctl_rise = 1'($urandom_range(0, 1));
            rgmii_rx_ctl_fall = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        rgmii_clk_en = 1'b0;
    endtask

    task automatic idle_samples(input int k);
        for (int i = 0; i < k; i++) gbe_sample(8'h00, 1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        start_cnt = 0;
        bad_cnt   = 0;
        pre_cnt   = 0;
    endtask

    // Wait (bounded) until the scoreboard has drained.
    task automatic drain();
        repeat (3) @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        #1;
    endtask

    // Gigabit frame from pl[]; payload byte err_idx carries RX_ER, and
    // mii_sel flips high at payload byte tog_idx (-1 disables either).
    task automatic send_gbe_frame(input int n_pre, input int n_bytes, input int err_idx, input int tog_idx);
        logic bad;
        bad = (err_idx >= 0);
        for (int i = 0; i < n_pre; i++) gbe_sample(8'h55, 1'b1, 1'b0);
        gbe_sample(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < n_bytes; i++) begin
            if (i == tog_idx) rgmii_mii_sel = 1'b1;
            if (i == n_bytes - 1) sb.push_back({pl[i], 1'b1, bad});
            else                  sb.push_back({pl[i], 1'b0, 1'b0});
            gbe_sample(pl[i], 1'b1, (i == err_idx));
        end
        gbe_sample(8'h00, 1'b0, 1'b0);
        rgmii_mii_sel = 1'b0;
    endtask

    // MII frame from nb[] with gap idle cycles between qualified samples.
    task automatic send_mii_frame(input int n_pre, input int n_nib, input int gap);
        int nbytes;
        logic odd;
        nbytes = n_nib / 2;
        odd    = (n_nib % 2) != 0;
        rgmii_mii_sel = 1'b1;
        for (int i = 0; i < n_pre; i++) mii_sample(4'h5, 1'b1, 1'b0, gap);
        mii_sample(4'hD, 1'b1, 1'b0, gap);
        for (int i = 0; i < n_nib; i++) begin
            if (i % 2 == 1) begin
                if (i / 2 == nbytes - 1) sb.push_back({nb[i], nb[i-1], 1'b1, odd});
                else                     sb.push_back({nb[i], nb[i-1], 1'b0, 1'b0});
            end
            mii_sample(nb[i], 1'b1, 1'b0, gap);
        end
        mii_sample(4'h0, 1'b0, 1'b0, gap);
        rgmii_mii_sel = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rgmii_clk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 11'h000) begin
            failures++;
            $display("FAIL reset_axis got data=%02h v=%b l=%b u=%b required all 0",
                     m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser);
        end
        checks++;
        if ({stat_start_packet, stat_error_bad_frame, stat_error_preamble} !== 3'b000) begin
            failures++;
            $display("FAIL reset_stats got %b%b%b required 000",
                     stat_start_packet, stat_error_bad_frame, stat_error_preamble);
        end
        rgmii_clk_en = 1'b0;
        rst = 1'b0;
        idle_samples(3);
    endtask

    task automatic test_gbe_basic();
        clear_counts();
        for (int i = 0; i < 60; i++) pl[i] = 8'(i + 1);
        send_gbe_frame(7, 60, -1, -1);
        idle_samples(2);
        drain();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL gbe_drain got %0d pending required 0", sb.size()); end
        checks++;
        if (start_cnt != 1) begin failures++; $display("FAIL gbe_start got %0d required 1", start_cnt); end
        checks++;
        if (bad_cnt != 0 || pre_cnt != 0) begin
            failures++;
            $display("FAIL gbe_errs got bad=%0d pre=%0d required 0 0", bad_cnt, pre_cnt);
        end
    endtask

    task automatic test_mii();
        clear_counts();
        nb[0] = 4'h0; nb[1] = 4'h1; nb[2] = 4'hF; nb[3] = 4'hE;
        send_mii_frame(15, 4, 9);
        idle_samples(2);
        drain();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL mii_drain got %0d pending required 0", sb.size()); end
        checks++;
        if (start_cnt != 1 || bad_cnt != 0) begin
            failures++;
            $display("FAIL mii_stats got start=%0d bad=%0d required 1 0", start_cnt, bad_cnt);
        end
    endtask

    task automatic test_rx_error();
        clear_counts();
        for (int i = 0; i < 20; i++) pl[i] = 8'(8'hA0 + i);
        send_gbe_frame(7, 20, 4, -1);
        idle_samples(2);
        drain();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL err_drain got %0d pending required 0", sb.size()); end
        checks++;
        if (bad_cnt != 1) begin failures++; $display("FAIL err_bad_frame got %0d required 1", bad_cnt); end
    endtask

    task automatic test_bad_preamble();
        clear_counts();
        gbe_sample(8'h55, 1'b1, 1'b0);
        gbe_sample(8'h55, 1'b1, 1'b0);
        gbe_sample(8'h57, 1'b1, 1'b0);
        gbe_sample(8'h55, 1'b1, 1'b0);
        gbe_sample(8'hD5, 1'b1, 1'b0);
        gbe_sample(8'h11, 1'b1, 1'b0);
        gbe_sample(8'h22, 1'b1, 1'b0);
        idle_samples(3);
        drain();
        checks++;
        if (pre_cnt != 1 || start_cnt != 0) begin
            failures++;
            $display("FAIL preamble_err got pre=%0d start=%0d required 1 0", pre_cnt, start_cnt);
        end
        clear_counts();
        for (int i = 0; i < 6; i++) pl[i] = 8'(8'h40 + 3 * i);
        send_gbe_frame(3, 6, -1, -1);
        idle_samples(2);
        drain();
        checks++;
        if (sb.size() != 0 || start_cnt != 1) begin
            failures++;
            $display("FAIL preamble_recover got pending=%0d start=%0d required 0 1", sb.size(), start_cnt);
        end
    endtask

    task automatic test_mii_odd();
        clear_counts();
        nb[0] = 4'h2; nb[1] = 4'h3; nb[2] = 4'h4;
        send_mii_frame(7, 3, 0);
        idle_samples(2);
        drain();
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL odd_drain got %0d pending required 0", sb.size()); end
        checks++;
        if (bad_cnt != 1) begin failures++; $display("FAIL odd_bad_frame got %0d required 1", bad_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        for (int i = 0; i < 7; i++) gbe_sample(8'h55, 1'b1, 1'b0);
        gbe_sample(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) sb.push_back({8'(8'hC0 + i - 1), 1'b0, 1'b0});
            gbe_sample(8'(8'hC0 + i), 1'b1, 1'b0);
        end
        drain();
        rst = 1'b1;
        rgmii_rx_ctl_rise = 1'b1;
        rgmii_rx_ctl_fall = 1'b1;
        rgmii_clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_start_packet} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_outputs got v=%b l=%b u=%b s=%b required 0",
                     m_axis_tvalid, m_axis_tlast, m_axis_tuser, stat_start_packet);
        end
        rst = 1'b0;
        clear_counts();
        gbe_sample(8'h55, 1'b1, 1'b0);
        gbe_sample(8'h55, 1'b1, 1'b0);
        gbe_sample(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) gbe_sample(8'(i), 1'b1, 1'b0);
        idle_samples(3);
        drain();
        checks++;
        if (sb.size() != 0 || start_cnt != 0 || bad_cnt != 0 || pre_cnt != 0) begin
            failures++;
            $display("FAIL midrst_tail got pending=%0d start=%0d bad=%0d pre=%0d required all 0",
                     sb.size(), start_cnt, bad_cnt, pre_cnt);
        end
        clear_counts();
        for (int i = 0; i < 8; i++) pl[i] = 8'(8'h5A ^ (8'h11 * i));
        send_gbe_frame(7, 8, -1, 3);
        idle_samples(2);
        drain();
        checks++;
        if (sb.size() != 0 || start_cnt != 1 || bad_cnt != 0) begin
            failures++;
            $display("FAIL midrst_next_frame got pending=%0d start=%0d bad=%0d required 0 1 0",
                     sb.size(), start_cnt, bad_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_gbe_basic();
        test_mii();
        test_rx_error();
        test_bad_preamble();
        test_mii_odd();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
